hamming_encoder: RTL
====================

Name: hamming_encoder

Overview:
Streaming SECDED (extended Hamming) encoder. It is the transmit-side counterpart of hamming_checker. Each accepted data word becomes a 2^P_BITS-bit codeword whose layout is exactly what hamming_checker consumes. A 2-entry output buffer with valid/ready handshakes on both sides gives full throughput and registered backpressure. Optional per-word error injection lets benches drive corrupted codewords into the checker.

Parameters:
P_BITS, 3, number of Hamming parity bits, excluding the overall parity bit.
CNT_W, 16, width of the accepted-word counter.
Derived, not overridable:
- CW_W = 1<<P_BITS (codeword width).
- D_W = CW_W - P_BITS - 1 (data width).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset; asynchronous, active-high.
in_data  in  D_W  data word to encode.
in_mask  in  CW_W  error-injection mask, XORed into the codeword; 0 gives a clean codeword.
in_valid  in  1  in_data and in_mask are valid.
in_ready  out  1  encoder can accept a word; driven from a register.
out_code  out  CW_W  encoded codeword.
out_valid  out  1  out_code is valid.
out_ready  in  1  sink accepts out_code.
word_cnt  out  CNT_W  number of words accepted since reset.

Behaviour:
- Codeword layout, indices 0..CW_W-1:
  - Bit 0: overall parity, the XOR of bits 1..CW_W-1. The codeword therefore has even weight.
  - Bits at indices 2^k, k = 0..P_BITS-1: parity p_k, the XOR of every data-bearing index with bit k of the index set.
  - Remaining indices: data bits in ascending order, in_data[0] at the lowest free index (index 3).
- Injection:
  - out_code = encoded word XOR in_mask, with in_mask captured in the same cycle as in_data.
  - Parity is computed on clean data, before the mask is applied.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_code must stay stable while out_valid && !out_ready.
- Buffer: main register plus skid register, each holding a codeword and a valid bit.
  - Input transfer with the main register empty, or the main register draining this cycle: the word goes to the main register. Latency is 1 cycle from acceptance to out_valid.
  - Input transfer while the main register is held (out_valid && !out_ready): the word goes to the skid register.
  - Output transfer with the skid register full: the skid word moves to the main register in the same edge.
  - Simultaneous input and output transfers with the skid register empty: the new word replaces the main word. out_valid stays 1, so throughput is 1 word/cycle.
  - in_ready = !skid_valid, registered. It deasserts the cycle after the skid register fills and reasserts the cycle after it drains.
  - Ordering is strictly FIFO.
- word_cnt increments by 1 on every input transfer and wraps from 2^CNT_W-1 to 0.
- Reset, asserted at any time including mid-transfer:
  - out_valid = 0, out_code = 0, skid empty, in_ready = 1, word_cnt = 0.
  - Buffered words are discarded.
  - After deassertion, in_ready = 1 on the first edge.
- Encoding logic is purely combinational ahead of the buffer; there is no extra pipeline stage.

Decomposition:
- Package hamming_pkg holds:
  - a function for CW_W/D_W derivation from P_BITS;
  - an is_pow2 index helper;
  - the index-to-data-bit mapping function, shared with hamming_checker so both ends use one layout definition.
- One sub-module, hamming_enc_core: combinational data to clean codeword, parameterised by P_BITS.
- hamming_encoder instantiates hamming_enc_core and implements the skid buffer, injection and counter.

Test Plan (P_BITS=3, so CW_W=8, D_W=4):
- Single encodes: reset, then in_data=4'hB, in_mask=0, out_ready=1 -> out_code=8'hAA one cycle later. in_data=0 -> 8'h00. in_data=4'hF -> 8'hFF. Each codeword has even weight.
- Injection: in_data=4'hB, in_mask=8'h08 -> out_code=8'hA2. Feeding it to hamming_checker returns data=4'hB with a single-error indication.
- Backpressure: stream 4'h1,4'h2,4'h3 back-to-back with out_ready=0 -> in_ready drops after 2 accepts, word_cnt=2. Raise out_ready -> the three codewords of 1, 2, 3 emerge in order, no loss or duplication.
- Full throughput: 16 consecutive words (all 16 data values) with out_ready=1 -> one codeword per cycle. Each matches a reference encode and passes hamming_checker with no error; word_cnt=16.
- Reset mid-operation: assert rst with both buffer entries full -> out_valid=0, word_cnt=0, in_ready=1 immediately (asynchronously). No stale codeword appears after release.
- Counter wrap: CNT_W=4, 17 input transfers -> word_cnt=1.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared SECDED codeword layout helpers for hamming_encoder and hamming_checker.
// Combinational functions only; no state.
// Both ends derive widths and the data-bit placement from these definitions.
package hamming_pkg;

    // Codeword width for a given number of Hamming parity bits.
    function automatic int cw_w(input int p_bits);
        return 1 << p_bits;
    endfunction

    // Data width: codeword minus Hamming parity bits minus the overall parity bit.
    function automatic int d_w(input int p_bits);
        return (1 << p_bits) - p_bits - 1;
    endfunction

    // True for indices that carry a Hamming parity bit (1, 2, 4, ...).
    function automatic bit is_pow2(input int idx);
        return (idx > 0) && ((idx & (idx - 1)) == 0);
    endfunction

    // Data bit number carried at codeword index idx (valid for data-bearing indices only).
    function automatic int data_bit_of(input int idx);
        int n;
        n = 0;
        for (int i = 1; i < idx; i++) begin
            if (!is_pow2(i)) begin
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/hamming_enc_core.sv
// Combinational SECDED encode: data word to clean extended-Hamming codeword.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module hamming_enc_core
    import hamming_pkg::*;
#(
    parameter int P_BITS = 3
) (
    input  logic [d_w(P_BITS)-1:0]  data,
    output logic [cw_w(P_BITS)-1:0] code
);

    localparam int CW_W = cw_w(P_BITS);

    logic [CW_W-1:0] placed;
    logic            par;

    // Scatter data bits onto the non-parity indices, zeros elsewhere.
    for (genvar j = 0; j < CW_W; j++) begin : g_place
        if (j != 0 && !is_pow2(j)) begin : g_data
            assign placed[j] = data[data_bit_of(j)];
        end else begin : g_zero
            assign placed[j] = 1'b0;
        end
    end

    // Fill in Hamming parity bits, then the overall parity over bits 1..CW_W-1.
    always_comb begin
        code = placed;
        par  = 1'b0;
        for (int k = 0; k < P_BITS; k++) begin
            par = 1'b0;
            for (int j = 1; j < CW_W; j++) begin
                if (!is_pow2(j) && (((j >> k) & 1) == 1)) begin
                    par = par ^ placed[j];
                end
            end
            code[1 << k] = par;
        end
        code[0] = ^code[CW_W-1:1];
    end

endmodule

// File: rtl/hamming_encoder.sv
// Streaming SECDED encoder with per-word error injection and an accepted-word counter.
// Latency: 1 cycle from input acceptance to out_valid.
// Backpressure: main + skid register; in_ready is registered and drops once the skid fills.
module hamming_encoder
    import hamming_pkg::*;
#(
    parameter int P_BITS = 3,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [d_w(P_BITS)-1:0]  in_data,
    input  logic [cw_w(P_BITS)-1:0] in_mask,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [cw_w(P_BITS)-1:0] out_code,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        word_cnt
);

    localparam int CW_W = cw_w(P_BITS);

    logic [CW_W-1:0]  clean_code;
    logic [CW_W-1:0]  new_code;
    logic             in_fire;
    logic             out_fire;

    logic [CW_W-1:0]  main_code_q, main_code_d;
    logic             main_vld_q,  main_vld_d;
    logic [CW_W-1:0]  skid_code_q, skid_code_d;
    logic             skid_vld_q,  skid_vld_d;
    logic             in_rdy_q,    in_rdy_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    hamming_enc_core #(
        .P_BITS (P_BITS)
    ) u_core (
        .data (in_data),
        .code (clean_code)
    );

    // Parity is taken on clean data; the mask only corrupts the transmitted word.
    assign new_code = clean_code ^ in_mask;
    assign in_fire  = in_valid && in_rdy_q;
    assign out_fire = main_vld_q && out_ready;

    // Next-state for the two-entry buffer, ready flag and counter.
    always_comb begin
        main_code_d = main_code_q;
        main_vld_d  = main_vld_q;
        skid_code_d = skid_code_q;
        skid_vld_d  = skid_vld_q;
        cnt_d       = cnt_q;

        if (out_fire) begin
            if (skid_vld_q) begin
                main_code_d = skid_code_q;
                main_vld_d  = 1'b1;
                skid_vld_d  = 1'b0;
            end else begin
                main_vld_d  = 1'b0;
            end
        end

        // in_fire implies the skid is empty, so a skid promotion and a new word never collide.
        if (in_fire) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!main_vld_q || out_fire) begin
                main_code_d = new_code;
                main_vld_d  = 1'b1;
            end else begin
                skid_code_d = new_code;
                skid_vld_d  = 1'b1;
            end
        end

        in_rdy_d = !skid_vld_d;
    end

    // Buffer, ready and counter registers; reset discards any buffered words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_code_q <= '0;
            main_vld_q  <= 1'b0;
            skid_code_q <= '0;
            skid_vld_q  <= 1'b0;
            in_rdy_q    <= 1'b1;
            cnt_q       <= '0;
        end else begin
            main_code_q <= main_code_d;
            main_vld_q  <= main_vld_d;
            skid_code_q <= skid_code_d;
            skid_vld_q  <= skid_vld_d;
            in_rdy_q    <= in_rdy_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_rdy_q;
    assign out_code  = main_code_q;
    assign out_valid = main_vld_q;
    assign word_cnt  = cnt_q;

endmodule
